// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array feeder: FSM encoding and default sizes.
package systolic_feeder_pkg;

    localparam int unsigned DefDataSize = 8;
    localparam int unsigned DefSize     = 3;

    typedef enum logic [2:0] {
        StWFill  = 3'd0,
        StWBurst = 3'd1,
        StWaitIn = 3'd2,
        StStream = 3'd3,
        StDrain  = 3'd4
    } feeder_state_e;

endpackage

// File: rtl/feeder_delay_line.sv
// One lane of the activation skew: depth pipeline registers followed by an output register.
module feeder_delay_line #(
    parameter int unsigned depth     = 0,
    parameter int unsigned data_size = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [data_size-1:0] in_data,
    input  logic                 in_valid,
    output logic [data_size-1:0] out_data,
    output logic                 out_valid
);

    logic [data_size-1:0] tap_data;
    logic                 tap_valid;
    logic [data_size-1:0] out_data_q;
    logic                 out_valid_q;

    if (depth == 0) begin : g_direct
        assign tap_data  = in_data;
        assign tap_valid = in_valid;
    end else begin : g_shift
        logic [data_size-1:0] data_q  [depth];
        logic                 valid_q [depth];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < depth; i++) begin
                    data_q[i]  <= '0;
                    valid_q[i] <= 1'b0;
                end
            end else begin
                data_q[0]  <= in_data;
                valid_q[0] <= in_valid;
                for (int i = 1; i < depth; i++) begin
                    data_q[i]  <= data_q[i-1];
                    valid_q[i] <= valid_q[i-1];
                end
            end
        end

        assign tap_data  = data_q[depth-1];
        assign tap_valid = valid_q[depth-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= tap_data;
            out_valid_q <= tap_valid;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: rtl/systolic_feeder.sv
// Loads a weight matrix row by row, bursts it into the array, then streams skewed activations.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int unsigned data_size = DefDataSize,
    parameter int unsigned size      = DefSize
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [data_size*size-1:0] w_vec,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [data_size*size-1:0] in_vec,
    input  logic                      in_last,
    output logic [data_size*size-1:0] data_stream,
    output logic [data_size*size-1:0] w_stream,
    output logic                      set_w,
    output logic [size-1:0]           lane_valid,
    output logic                      busy
);

    localparam int unsigned VecW = data_size * size;
    localparam int unsigned CntW = (size > 1) ? $clog2(size) : 1;
    localparam logic [CntW-1:0] LastIdx   = CntW'(size - 1);
    localparam logic [CntW-1:0] DrainLast = CntW'((size > 1) ? size - 2 : 0);

    feeder_state_e   state_q, state_d;
    logic [CntW-1:0] r_cnt_q, r_cnt_d;
    logic [CntW-1:0] b_cnt_q, b_cnt_d;
    logic [VecW-1:0] wbuf_q [size];
    logic [VecW-1:0] wbuf_d [size];
    logic            set_w_q, set_w_d;
    logic [VecW-1:0] w_stream_q, w_stream_d;
    logic [VecW-1:0] stage_data_q;
    logic            stage_valid_q;
    logic            w_hs, in_hs;

    assign w_ready  = (state_q == StWFill);
    assign in_ready = (state_q == StWaitIn) || (state_q == StStream);
    assign busy     = (state_q != StWFill);
    assign w_hs     = w_valid & w_ready;
    assign in_hs    = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        r_cnt_d = r_cnt_q;
        b_cnt_d = b_cnt_q;
        wbuf_d  = wbuf_q;
        unique case (state_q)
            StWFill: begin
                if (w_hs) begin
                    wbuf_d[r_cnt_q] = w_vec;
                    if (r_cnt_q == LastIdx) begin
                        r_cnt_d = '0;
                        b_cnt_d = '0;
                        state_d = StWBurst;
                    end else begin
                        r_cnt_d = r_cnt_q + 1'b1;
                    end
                end
            end
            StWBurst: begin
                if (b_cnt_q == LastIdx) begin
                    b_cnt_d = '0;
                    state_d = StWaitIn;
                end else begin
                    b_cnt_d = b_cnt_q + 1'b1;
                end
            end
            StWaitIn: begin
                b_cnt_d = '0;
                if (in_hs) begin
                    state_d = in_last ? StDrain : StStream;
                end
            end
            StStream: begin
                if (in_hs && in_last) begin
                    b_cnt_d = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (b_cnt_q == DrainLast) begin
                    b_cnt_d = '0;
                    state_d = StWFill;
                end else begin
                    b_cnt_d = b_cnt_q + 1'b1;
                end
            end
            default: state_d = StWFill;
        endcase
        // Derived from next state so the registered burst lines up with the W_BURST cycles.
        set_w_d    = (state_d == StWBurst);
        w_stream_d = set_w_d ? wbuf_d[b_cnt_d] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StWFill;
            r_cnt_q       <= '0;
            b_cnt_q       <= '0;
            set_w_q       <= 1'b0;
            w_stream_q    <= '0;
            stage_data_q  <= '0;
            stage_valid_q <= 1'b0;
            for (int i = 0; i < size; i++) begin
                wbuf_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            r_cnt_q       <= r_cnt_d;
            b_cnt_q       <= b_cnt_d;
            set_w_q       <= set_w_d;
            w_stream_q    <= w_stream_d;
            stage_data_q  <= in_hs ? in_vec : '0;
            stage_valid_q <= in_hs;
            wbuf_q        <= wbuf_d;
        end
    end

    assign set_w    = set_w_q;
    assign w_stream = w_stream_q;

    for (genvar k = 0; k < size; k++) begin : g_lane
        feeder_delay_line #(
            .depth     (k),
            .data_size (data_size)
        ) u_delay_line (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_data   (stage_data_q[(size-k)*data_size-1 -: data_size]),
            .in_valid  (stage_valid_q),
            .out_data  (data_stream[(size-k)*data_size-1 -: data_size]),
            .out_valid (lane_valid[k])
        );
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: weight load/burst, skewed streaming, reset mid-burst.
module tb_systolic_feeder;

    localparam int DS = 8;
    localparam int SZ = 3;
    localparam int VW = DS * SZ;

    logic          clk;
    logic          rst_n;
    logic          w_valid;
    logic          w_ready;
    logic [VW-1:0] w_vec;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_vec;
    logic          in_last;
    logic [VW-1:0] data_stream;
    logic [VW-1:0] w_stream;
    logic          set_w;
    logic [SZ-1:0] lane_valid;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    systolic_feeder #(
        .data_size (DS),
        .size      (SZ)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_vec       (w_vec),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .in_last     (in_last),
        .data_stream (data_stream),
        .w_stream    (w_stream),
        .set_w       (set_w),
        .lane_valid  (lane_valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic          il;
        logic          wv;
        logic [VW-1:0] vec;
        logic [VW-1:0] exp_data;
        logic [SZ-1:0] exp_lv;
        logic          exp_busy;
        logic          exp_inr;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs of record i are presented before edge i; its expectations are sampled after it.
    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            in_valid = tbl[i].iv;
            in_last  = tbl[i].il;
            in_vec   = tbl[i].vec;
            w_valid  = tbl[i].wv;
            w_vec    = tbl[i].wv ? 24'hFFFFFF : 24'h0;
            step();
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_vec   = '0;
            w_valid  = 1'b0;
            w_vec    = '0;
            check($sformatf("data_stream[%0d]", i), data_stream, tbl[i].exp_data);
            check($sformatf("lane_valid[%0d]", i), lane_valid, tbl[i].exp_lv);
            check($sformatf("busy[%0d]", i), busy, tbl[i].exp_busy);
            check($sformatf("w_ready[%0d]", i), w_ready, !tbl[i].exp_busy);
            check($sformatf("in_ready[%0d]", i), in_ready, tbl[i].exp_inr);
            check($sformatf("set_w_quiet[%0d]", i), set_w, 1'b0);
            check($sformatf("w_stream_quiet[%0d]", i), w_stream, 0);
        end
    endtask

    task automatic load_weights(input logic [VW-1:0] r0, input logic [VW-1:0] r1,
                                input logic [VW-1:0] r2, input int gap, input bit abort);
        logic [VW-1:0] rows [3];
        rows = '{r0, r1, r2};
        for (int i = 0; i < 3; i++) begin
            w_valid = 1'b1;
            w_vec   = rows[i];
            check("w_ready_fill", w_ready, 1'b1);
            check("in_ready_fill", in_ready, 1'b0);
            step();
            w_valid = 1'b0;
            w_vec   = '0;
            if (i < 2) begin
                check("set_w_early", set_w, 1'b0);
                check("busy_fill", busy, 1'b0);
                repeat (gap) step();
            end
        end
        in_valid = 1'b0;
        in_vec   = '0;
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("set_w_burst[%0d]", c), set_w, (c < 3) ? 1'b1 : 1'b0);
            check($sformatf("w_stream_burst[%0d]", c), w_stream, (c < 3) ? rows[c] : 0);
            check($sformatf("lane_valid_idle[%0d]", c), lane_valid, 0);
            if (c >= 3) check("in_ready_wait", in_ready, 1'b1);
            if (abort && c == 1) return;
            if (c < 4) step();
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 24'h0A0B0C, 24'h000000, 3'b000, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h0A0000, 3'b001, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000B00, 3'b010, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h00000C, 3'b100, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 24'h111213, 24'h000000, 3'b000, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 24'h212223, 24'h110000, 3'b001, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 24'h313233, 24'h211200, 3'b011, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 24'h000000, 24'h312213, 3'b111, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 24'h414243, 24'h003223, 3'b110, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h410033, 3'b101, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h004200, 3'b010, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000043, 3'b100, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0};

        rst_n    = 1'b0;
        w_valid  = 1'b0;
        w_vec    = '0;
        in_valid = 1'b0;
        in_vec   = '0;
        in_last  = 1'b0;
        #1;
        check("rst_set_w", set_w, 1'b0);
        check("rst_w_stream", w_stream, 0);
        check("rst_data_stream", data_stream, 0);
        check("rst_lane_valid", lane_valid, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_w_ready", w_ready, 1'b1);
        check("rst_in_ready", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        // Activations offered alongside weights in W_FILL must be ignored.
        in_valid = 1'b1;
        in_vec   = 24'h5A5A5A;
        in_last  = 1'b1;
        load_weights(24'h010203, 24'h040506, 24'h070809, 2, 1'b0);

        run_vectors(0, 4);

        load_weights(24'h010203, 24'h040506, 24'h070809, 0, 1'b0);
        run_vectors(5, 13);

        // Any stray weight accepted during STREAM would shorten this load to two rows.
        load_weights(24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3, 1, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midburst_set_w", set_w, 1'b0);
        check("midburst_w_stream", w_stream, 0);
        check("midburst_busy", busy, 1'b0);
        check("midburst_w_ready", w_ready, 1'b1);
        check("midburst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        in_valid = 1'b1;
        in_vec   = 24'h0F0F0F;
        for (int i = 0; i < 3; i++) begin
            check("post_rst_in_ready", in_ready, 1'b0);
            check("post_rst_set_w", set_w, 1'b0);
            step();
        end
        load_weights(24'h202122, 24'h303132, 24'h404142, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 The module SHALL have parameter data_size, default 8, meaning the bit width of one lane element.
REQ-002 The module SHALL have parameter size, default 3, meaning the lane count and the systolic array dimension.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have ports w_valid (input, 1), w_ready (output, 1) and w_vec (input, data_size*size): the weight-row handshake.
REQ-006 The module SHALL have ports in_valid (input, 1), in_ready (output, 1), in_vec (input, data_size*size) and in_last (input, 1): the activation-vector handshake; in_last marks the final vector.
REQ-007 The module SHALL have ports data_stream (output, data_size*size), w_stream (output, data_size*size) and set_w (output, 1): the downstream array feed.
REQ-008 The module SHALL have port lane_valid (output, size bits): bit k qualifies lane k of data_stream.
REQ-009 The module SHALL have port busy (output, 1): high in any state other than W_FILL.
REQ-010 On every packed bus, lane k SHALL occupy bits [(size-k)*data_size-1 -: data_size], so lane 0 is the MSBs.

Function
REQ-011 The FSM SHALL have states W_FILL, W_BURST, WAIT_IN, STREAM and DRAIN; the reset state is W_FILL.
REQ-012 W_FILL: w_ready=1; each w_valid&w_ready handshake stores w_vec into weight buffer row r_cnt and increments r_cnt; when the size-th row is accepted, go to W_BURST and clear r_cnt.
REQ-013 W_BURST: set_w=1 for exactly size consecutive cycles with w_stream = buffer row 0, 1, ..., size-1 in order, then go to WAIT_IN; set_w is never deasserted mid-burst.
REQ-014 set_w and w_stream SHALL be registered outputs; outside W_BURST, set_w=0 and w_stream=0.
REQ-015 in_ready SHALL be 1 only in WAIT_IN and STREAM; w_ready SHALL be 1 only in W_FILL.
REQ-016 WAIT_IN: an accepted vector enters the skew path and the FSM goes to STREAM; if that vector has in_last=1, go directly to DRAIN.
REQ-017 Skew: lane k of a vector accepted at edge t SHALL appear on data_stream lane k, with lane_valid[k]=1, after edge t+1+k.
REQ-018 A cycle with no handshake in STREAM (bubble) SHALL inject zero data with lane_valid=0 into every lane's delay line, and the skew continues to advance.
REQ-019 STREAM: an accepted vector with in_last=1 moves the FSM to DRAIN.
REQ-020 DRAIN SHALL last exactly size-1 cycles with bubbles injected, then return to W_FILL, keeping the weight buffer contents.
REQ-021 The delay line for lane k SHALL be k registers deep plus one output register; data is not arithmetically modified (pure width-preserving copy).
REQ-022 While in W_FILL, W_BURST or WAIT_IN, data_stream=0 and lane_valid=0 once the skew has emptied.

Reset
REQ-023 While rst_n=0, the block SHALL clear the FSM to W_FILL, r_cnt and the burst counter to 0, all delay lines and the weight buffer to 0, and all outputs to 0.
REQ-024 Reset SHALL take effect immediately, even mid-burst or mid-stream; the partial burst is abandoned (set_w falls asynchronously).

Structure
REQ-025 A shared package SHALL hold the FSM state encoding and the default data_size and size constants.
REQ-026 One sub-module, feeder_delay_line (parameters depth and data_size, data plus valid bit), SHALL be instantiated once per lane via generate.

Verification
REQ-027 The bench SHALL load weight rows 01_02_03, 04_05_06 and 07_08_09 with gaps between handshakes, and check set_w is high for exactly 3 contiguous cycles with w_stream 010203, 040506, 070809 in order.
REQ-028 The bench SHALL send vector 0A_0B_0C with in_last=1 at edge t, and check lane0=0A after t+1, lane1=0B after t+2, lane2=0C after t+3, with all other lanes/cycles zero and lane_valid matching.
REQ-029 The bench SHALL send 3 back-to-back vectors, then a bubble, then a last vector, and check that each output cycle's lane_valid equals the correct diagonal pattern (e.g. 100, 110, 111, 011, ...).
REQ-030 The bench SHALL drive w_valid=1 during STREAM and check w_ready=0 with no weight change; after DRAIN (2 cycles), check busy=0 and w_ready=1.
REQ-031 The bench SHALL assert rst_n=0 on the second burst cycle and check set_w=0 immediately, the state is W_FILL, and a fresh 3-row load is required before in_ready rises.
REQ-032 The bench SHALL drive w_valid and in_valid together in W_FILL and check that only the weight row is accepted (in_ready=0).
